// File: rtl/reg_bus_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reg_bus_pkg                                                           |
// | Shared types and width helpers for the register-bus sequencer.        |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package reg_bus_pkg;

   // Sequencer states: DONE is the single-cycle completion of a rejected move
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      LOAD  = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Index width for n items, never narrower than one bit
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width of the settle counter; it counts down from SETTLE-1 to zero
   function automatic int settle_cnt_w(input int settle);
      return clog2_min1(settle);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter                                                            |
// | Combinational round-robin pick: first valid index at or after the     |
// | pointer, wrapping. Outputs one-hot grant, its index and any-valid.    |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module rr_arbiter
   import reg_bus_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int GW   = clog2_min1(NREQ)
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [GW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [GW-1:0]   o_grant_idx,
   output logic            o_any
);

   int w_j;

   // Scan from the pointer outward; the first valid requester found wins
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      w_j         = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_j = (int'(i_ptr) + k) % NREQ;
         if (!o_any && i_valid[w_j]) begin
            o_any        = 1'b1;
            o_grant_idx  = GW'(w_j);
            o_grant[w_j] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_bus_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reg_bus_sequencer                                                     |
// | Arbitrates register-to-register move requests and sequences the       |
// | shared 8-bit bus: drive source, settle, pulse destination EI, hold.   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module reg_bus_sequencer
   import reg_bus_pkg::*;
#(
   parameter  int NREG   = 8,
   parameter  int NREQ   = 2,
   parameter  int SETTLE = 2,
   localparam int IW     = clog2_min1(NREG),
   localparam int GW     = clog2_min1(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*IW-1:0] req_src,
   input  logic [NREQ*IW-1:0] req_dst,
   output logic [NREQ-1:0]    req_ready,
   output logic [IW-1:0]      bus_sel,
   output logic               bus_oe,
   output logic [NREG-1:0]    ei,
   output logic               done,
   output logic [GW-1:0]      done_id,
   output logic               err,
   output logic               busy
);

   localparam int              CW         = settle_cnt_w(SETTLE);
   localparam logic [CW-1:0]   c_cnt_load = CW'(SETTLE - 1);
   localparam logic [IW:0]     c_nreg_ext = (IW+1)'(NREG);
   localparam logic [NREG-1:0] c_ei_lsb   = NREG'(1);
   localparam logic [GW-1:0]   c_last_req = GW'(NREQ - 1);

   state_e          r_state;
   state_e          w_state_nxt;
   logic [GW-1:0]   r_rr_ptr;
   logic [GW-1:0]   w_gidx;
   logic [NREQ-1:0] w_grant;
   logic            w_any;
   logic [IW-1:0]   w_src;
   logic [IW-1:0]   w_dst;
   logic [IW-1:0]   r_dst;
   logic [IW-1:0]   r_bus_sel;
   logic [IW-1:0]   w_sel_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_bus_oe;
   logic            w_oe_nxt;
   logic [NREG-1:0] r_ei;
   logic [NREG-1:0] w_ei_nxt;
   logic            r_done;
   logic            w_done_nxt;
   logic            r_err;
   logic            w_err_nxt;
   logic [GW-1:0]   r_owner;
   logic            w_accept;
   logic            w_illegal;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .i_valid     (req_valid),
      .i_ptr       (r_rr_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_gidx),
      .o_any       (w_any)
   );

   // Pull the granted requester's source and destination out of the flat buses
   always_comb begin
      w_src = '0;
      w_dst = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gidx == GW'(i)) begin
            w_src = req_src[i*IW +: IW];
            w_dst = req_dst[i*IW +: IW];
         end
      end
   end

   // Self-moves and out-of-range indices are rejected without touching the bus
   assign w_illegal = (w_src == w_dst)
                   || ({1'b0, w_src} >= c_nreg_ext)
                   || ({1'b0, w_dst} >= c_nreg_ext);

   assign w_accept  = (r_state == IDLE) && w_any;
   assign req_ready = (r_state == IDLE) ? w_grant : '0;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus next values of every registered output
   always_comb begin
      w_state_nxt = r_state;
      w_oe_nxt    = r_bus_oe;
      w_sel_nxt   = r_bus_sel;
      w_ei_nxt    = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               if (w_illegal) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt = DRIVE;
                  w_oe_nxt    = 1'b1;
                  w_sel_nxt   = w_src;
                  w_cnt_nxt   = c_cnt_load;
               end
            end
         end
         DRIVE: begin
            if (r_cnt == '0) begin
               w_state_nxt = LOAD;
               w_ei_nxt    = c_ei_lsb << r_dst;
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         LOAD: begin
            w_state_nxt = HOLD;
            w_done_nxt  = 1'b1;
         end
         HOLD: begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
         end
      endcase
   end

   // Output, counter and per-move registers; EI comes straight from a flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_oe  <= 1'b0;
         r_bus_sel <= '0;
         r_ei      <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
         r_dst     <= '0;
         r_owner   <= '0;
         r_rr_ptr  <= '0;
      end else begin
         r_bus_oe  <= w_oe_nxt;
         r_bus_sel <= w_sel_nxt;
         r_ei      <= w_ei_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_cnt     <= w_cnt_nxt;
         if (w_accept) begin
            r_dst    <= w_dst;
            r_owner  <= w_gidx;
            r_rr_ptr <= (w_gidx == c_last_req) ? '0 : w_gidx + GW'(1);
         end
      end
   end

   assign bus_oe  = r_bus_oe;
   assign bus_sel = r_bus_sel;
   assign ei      = r_ei;
   assign done    = r_done;
   assign done_id = r_owner;
   assign err     = r_err;
   assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_reg_bus_sequencer                                                  |
// | Table-driven cycle vectors plus hand sequences for reset and NREG=6.  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_reg_bus_sequencer;

   typedef struct {
      int v; int s0; int d0; int s1; int d1;
      int rdy; int oe; int sel; int ei; int dn; int id; int er; int bsy;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [1:0] req_valid;
   logic [5:0] req_src;
   logic [5:0] req_dst;
   logic [1:0] req_ready;
   logic [2:0] bus_sel;
   logic       bus_oe;
   logic [7:0] ei;
   logic       done;
   logic       done_id;
   logic       err;
   logic       busy;

   logic [1:0] v6;
   logic [5:0] src6;
   logic [5:0] dst6;
   logic [1:0] ready6;
   logic [2:0] sel6;
   logic       oe6;
   logic [5:0] ei6;
   logic       done6;
   logic       id6;
   logic       err6;
   logic       busy6;

   int   n_pass;
   int   n_total;
   vec_t tbl[$];
   vec_t t;
   logic       m_prev_oe;
   logic [2:0] m_prev_sel;

   reg_bus_sequencer #(.NREG(8), .NREQ(2), .SETTLE(2)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
      .req_ready(req_ready), .bus_sel(bus_sel), .bus_oe(bus_oe), .ei(ei), .done(done),
      .done_id(done_id), .err(err), .busy(busy)
   );

   reg_bus_sequencer #(.NREG(6), .NREQ(2), .SETTLE(2)) u_dut6 (
      .clk(clk), .rst(rst), .req_valid(v6), .req_src(src6), .req_dst(dst6),
      .req_ready(ready6), .bus_sel(sel6), .bus_oe(oe6), .ei(ei6), .done(done6),
      .done_id(id6), .err(err6), .busy(busy6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Bus invariants sampled every cycle on the main instance
   always @(negedge clk) begin
      if (!rst) begin
         chk("inv ei onehot0", 32'($onehot0(ei)), 32'd1);
         if (ei != 8'd0) chk("inv ei needs oe", 32'(bus_oe), 32'd1);
         if (m_prev_oe && bus_oe) chk("inv sel stable", 32'(bus_sel), 32'(m_prev_sel));
      end
      m_prev_oe  <= bus_oe & ~rst;
      m_prev_sel <= bus_sel;
   end

   // One move on the NREG=6 instance from requester 0
   task automatic run6(input int s, input int d, input bit legal);
      v6   = 2'b01;
      src6 = {3'd0, 3'(s)};
      dst6 = {3'd0, 3'(d)};
      #1 chk("n6 ready", 32'(ready6), 32'd1);
      @(posedge clk); #1;
      v6 = 2'b00;
      if (!legal) begin
         chk("n6 rej done", 32'(done6), 32'd1);
         chk("n6 rej err", 32'(err6), 32'd1);
         chk("n6 rej id", 32'(id6), 32'd0);
         chk("n6 rej oe", 32'(oe6), 32'd0);
         chk("n6 rej ei", 32'(ei6), 32'd0);
         @(posedge clk); #1;
         chk("n6 rej idle busy", 32'(busy6), 32'd0);
         chk("n6 rej idle done", 32'(done6), 32'd0);
      end else begin
         for (int c = 1; c <= 4; c++) begin
            chk($sformatf("n6 c%0d oe", c), 32'(oe6), 32'd1);
            chk($sformatf("n6 c%0d sel", c), 32'(sel6), 32'(s));
            chk($sformatf("n6 c%0d ei", c), 32'(ei6), (c == 3) ? 32'(1 << d) : 32'd0);
            chk($sformatf("n6 c%0d done", c), 32'(done6), (c == 4) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
         end
         chk("n6 end busy", 32'(busy6), 32'd0);
         chk("n6 end oe", 32'(oe6), 32'd0);
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b1;
      req_valid = '0; req_src = '0; req_dst = '0;
      v6 = '0; src6 = '0; dst6 = '0;

      //          v  s0 d0 s1 d1  rdy oe sel ei    dn id er bsy
      tbl.push_back('{3, 2, 5, 3, 6, 1, 0, 0, 'h00, 0, 0, 0, 0});
      tbl.push_back('{2, 2, 5, 3, 6, 0, 1, 2, 'h00, 0, 0, 0, 1});
      tbl.push_back('{2, 2, 5, 3, 6, 0, 1, 2, 'h00, 0, 0, 0, 1});
      tbl.push_back('{2, 2, 5, 3, 6, 0, 1, 2, 'h20, 0, 0, 0, 1});
      tbl.push_back('{2, 2, 5, 3, 6, 0, 1, 2, 'h00, 1, 0, 0, 1});
      tbl.push_back('{2, 2, 5, 3, 6, 2, 0, 2, 'h00, 0, 0, 0, 0});
      tbl.push_back('{3, 2, 5, 3, 6, 0, 1, 3, 'h00, 0, 0, 0, 1});
      tbl.push_back('{3, 2, 5, 3, 6, 0, 1, 3, 'h00, 0, 0, 0, 1});
      tbl.push_back('{3, 2, 5, 3, 6, 0, 1, 3, 'h40, 0, 0, 0, 1});
      tbl.push_back('{3, 2, 5, 3, 6, 0, 1, 3, 'h00, 1, 1, 0, 1});
      tbl.push_back('{3, 2, 5, 3, 6, 1, 0, 3, 'h00, 0, 0, 0, 0});
      tbl.push_back('{2, 2, 5, 3, 6, 0, 1, 2, 'h00, 0, 0, 0, 1});
      tbl.push_back('{2, 2, 5, 3, 6, 0, 1, 2, 'h00, 0, 0, 0, 1});
      tbl.push_back('{2, 2, 5, 3, 6, 0, 1, 2, 'h20, 0, 0, 0, 1});
      tbl.push_back('{2, 2, 5, 3, 6, 0, 1, 2, 'h00, 1, 0, 0, 1});
      tbl.push_back('{2, 2, 5, 3, 6, 2, 0, 2, 'h00, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 3, 'h00, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 3, 'h00, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 3, 'h40, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 3, 'h00, 1, 1, 0, 1});
      tbl.push_back('{2, 0, 0, 0, 7, 2, 0, 3, 'h00, 0, 0, 0, 0});
      tbl.push_back('{2, 0, 0, 7, 2, 0, 1, 0, 'h00, 0, 0, 0, 1});
      tbl.push_back('{2, 0, 0, 7, 2, 0, 1, 0, 'h00, 0, 0, 0, 1});
      tbl.push_back('{2, 0, 0, 7, 2, 0, 1, 0, 'h80, 0, 0, 0, 1});
      tbl.push_back('{2, 0, 0, 7, 2, 0, 1, 0, 'h00, 1, 1, 0, 1});
      tbl.push_back('{2, 0, 0, 7, 2, 2, 0, 0, 'h00, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 7, 'h00, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 7, 'h00, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 7, 'h04, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 7, 'h00, 1, 1, 0, 1});
      tbl.push_back('{1, 3, 3, 0, 0, 1, 0, 7, 'h00, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 7, 'h00, 1, 0, 1, 1});
      tbl.push_back('{2, 0, 0, 4, 4, 2, 0, 7, 'h00, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 7, 'h00, 1, 1, 1, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 7, 'h00, 0, 0, 0, 0});

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset ready", 32'(req_ready), 32'd0);
      chk("reset oe", 32'(bus_oe), 32'd0);
      chk("reset sel", 32'(bus_sel), 32'd0);
      chk("reset ei", 32'(ei), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset done_id", 32'(done_id), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset ei6", 32'(ei6), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // One row per cycle: drive inputs, compare mid-cycle, advance
      for (int i = 0; i < tbl.size(); i++) begin
         t = tbl[i];
         req_valid = 2'(t.v);
         req_src   = {3'(t.s1), 3'(t.s0)};
         req_dst   = {3'(t.d1), 3'(t.d0)};
         @(negedge clk);
         chk($sformatf("row%0d ready", i), 32'(req_ready), t.rdy);
         chk($sformatf("row%0d oe", i), 32'(bus_oe), t.oe);
         chk($sformatf("row%0d sel", i), 32'(bus_sel), t.sel);
         chk($sformatf("row%0d ei", i), 32'(ei), t.ei);
         chk($sformatf("row%0d done", i), 32'(done), t.dn);
         chk($sformatf("row%0d err", i), 32'(err), t.er);
         chk($sformatf("row%0d busy", i), 32'(busy), t.bsy);
         if (t.dn != 0) chk($sformatf("row%0d done_id", i), 32'(done_id), t.id);
         @(posedge clk); #1;
      end
      req_valid = '0;

      // Reset in cycle 1 of a 1->4 move from requester 0 (leaves pointer at 1)
      req_valid = 2'b01;
      req_src   = {3'd0, 3'd1};
      req_dst   = {3'd0, 3'd4};
      @(negedge clk);
      chk("rstseq ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("rstseq oe before", 32'(bus_oe), 32'd1);
      chk("rstseq sel before", 32'(bus_sel), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstseq oe", 32'(bus_oe), 32'd0);
      chk("rstseq ei", 32'(ei), 32'd0);
      chk("rstseq done", 32'(done), 32'd0);
      chk("rstseq busy", 32'(busy), 32'd0);
      chk("rstseq sel", 32'(bus_sel), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("rstseq no ei", 32'(ei), 32'd0);
         chk("rstseq no done", 32'(done), 32'd0);
      end
      req_valid = 2'b11;
      req_src   = {3'd3, 3'd2};
      req_dst   = {3'd6, 3'd5};
      #1 chk("rstseq ptr grant", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("rstseq after done", 32'(done), 32'd1);
      chk("rstseq after id", 32'(done_id), 32'd0);
      @(posedge clk); #1;
      chk("rstseq after busy", 32'(busy), 32'd0);

      // NREG=6 instance: out-of-range destination, out-of-range source, top legal index
      run6(1, 7, 1'b0);
      run6(6, 0, 1'b0);
      run6(5, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_bus_sequencer.md
Name: reg_bus_sequencer

Overview:
- Controls the shared 8-bit data bus of the 8-bit CPU register file.
- Accepts register-to-register move requests from NREQ requesters, such as the control unit and the front-panel/manual entry. Requesters are arbitrated round-robin.
- Sequences each move in three steps: drive the source onto the bus, wait for settle, then pulse the destination register8 load enable (EI) for one clean cycle.
- Sits between requesters and the bank of register8 instances plus the bus mux.

Parameters:
- NREG, 8, number of register8 instances on the bus; IW = clog2(NREG), minimum 1.
- NREQ, 2, number of requesters (2..4).
- SETTLE, 2, cycles the bus is driven before EI is raised (>=1).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_src  in  NREQ*IW  source register index per requester; slice i = [i*IW +: IW].
- req_dst  in  NREQ*IW  destination register index per requester.
- req_ready  out  NREQ  one-hot acceptance strobe; combinational, only in IDLE.
- bus_sel  out  IW  index of the register driving the bus (registered).
- bus_oe  out  1  bus driver enable (registered).
- ei  out  NREG  one-hot load enables to the register8 EI inputs (registered, glitch-free).
- done  out  1  one-cycle pulse when a move completes.
- done_id  out  clog2(NREQ) (min 1)  requester that owned the completed move; valid with done.
- err  out  1  one-cycle pulse, coincident with done, for a rejected move.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, bus_oe=0, bus_sel=0, ei=0, done=0, done_id=0, err=0.
  - A move in flight is abandoned: no done, no ei pulse.
- Handshake:
  - In IDLE, if any req_valid is high, the arbiter picks grant g: the first valid index at or after rr_ptr, wrapping.
  - req_ready[g]=1 in that same cycle; the transfer is latched on that edge.
  - rr_ptr becomes (g+1) mod NREQ on that edge.
  - req_ready is all-zero outside IDLE. Requesters hold valid/src/dst until they see ready.
- Legality check at acceptance:
  - src==dst, or src>=NREG, or dst>=NREG: the move is rejected.
  - A rejected move goes to DONE; next cycle done=1, err=1, done_id=g.
  - No bus_oe and no ei for a rejected move.
- FSM for a legal move (accept edge = cycle 0):
  - IDLE -> DRIVE: bus_oe=1 and bus_sel=src from cycle 1. A counter holds DRIVE for SETTLE cycles.
  - DRIVE -> LOAD: in cycle SETTLE+1, ei[dst]=1, all other ei bits 0, bus still driven.
  - LOAD -> HOLD: in cycle SETTLE+2, ei=0 and the bus is still driven, giving hold time after the register latches.
    - done=1, done_id=g in this same cycle.
  - HOLD -> IDLE: in cycle SETTLE+3, bus_oe=0 and bus_sel holds its last value.
- Throughput: one legal move every SETTLE+3 cycles.
  - A new acceptance is possible in the IDLE cycle that follows HOLD.
  - A new acceptance after a rejected move is possible 2 cycles after the accept edge.
- Invariants:
  - ei is at most one-hot, and high for exactly 1 cycle per legal move.
  - ei is never high while bus_oe=0.
  - bus_sel is stable whenever bus_oe=1.
- Simultaneous requests: only one grant per acceptance cycle. The losers keep waiting, with no starvation; worst-case wait is NREQ-1 moves.
- req_valid dropped before acceptance: no effect, and the pointer does not move.

Decomposition:
- reg_bus_pkg:
  - state enum (IDLE, DRIVE, LOAD, HOLD, DONE);
  - a clog2-based width helper;
  - the SETTLE counter width.
- One sub-module, rr_arbiter (NREQ): combinational grant from valid plus pointer, producing one-hot grant, grant index and any-valid.

Test Plan:
- Reset mid-DRIVE (rst asserted in cycle 1 of a move 1->4): bus_oe, ei, done all 0 immediately, asynchronously; no ei[4] pulse ever follows; the next request is granted to requester 0.
- SETTLE=2, requester 0 moves 1->4 accepted at cycle 0: bus_oe=1, bus_sel=1 in cycles 1-4; ei=8'b0001_0000 only in cycle 3; done=1, done_id=0 in cycle 4; busy low from cycle 5.
- Both requesters valid at once (r0: 2->5, r1: 3->6), rr_ptr=0: r0 accepted at cycle 0; r1 accepted at cycle 5 with ei[6] in cycle 8; with both held valid again, r0 is granted next.
- Illegal moves: src=dst=3 -> done=1, err=1 one cycle after accept, ei stays 0, bus_oe stays 0. With NREG=6, dst=7 gives the same response.
- Back-to-back requests from requester 1 (0->7, then 7->2): the two ei pulses are 5 cycles apart. Between the moves, bus_sel changes only while bus_oe=0 or at the start of the next DRIVE.
